// File: rtl/ser3w_reg_slave.sv
// 3-wire serial register slave: oversampled bus decode, byte register file, read-back and local read port.
// Latency: SYNC_STAGES+1 i_clk from bus edge to action; o_loc_data 1 cycle; no backpressure (bus timing is master-paced).
module ser3w_reg_slave #(
  parameter int          ADDR_W      = 7,
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  RESET_VAL   = 8'h00
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_ser_ce,
  input  logic              i_ser_clk,
  input  logic              i_ser_data,
  output logic              o_ser_data,
  output logic              o_ser_oe,
  output logic              o_wr_valid,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [7:0]        o_wr_data,
  output logic              o_rd_valid,
  output logic              o_busy,
  input  logic [ADDR_W-1:0] i_loc_addr,
  output logic [7:0]        o_loc_data
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {IDLE, CMD, WDATA, RDATA, DONE} state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] ce_sync, clk_sync, data_sync;
  logic                   ce_s, clk_s, data_s, clk_prev;
  logic                   rise, fall;
  logic [3:0]             cnt;
  logic [7:0]             sh, tx;
  logic [7:0]             sh_in;
  logic [ADDR_W-1:0]      idx;
  logic [7:0]             file [DEPTH];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ce_sync   <= '0;
      clk_sync  <= '0;
      data_sync <= '0;
      clk_prev  <= 1'b0;
    end else begin
      ce_sync   <= {ce_sync[SYNC_STAGES-2:0], i_ser_ce};
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], i_ser_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], i_ser_data};
      clk_prev  <= clk_s;
    end
  end

  assign ce_s   = ce_sync[SYNC_STAGES-1];
  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];
  assign o_busy = ce_s;

  // Edges only count while the synced CE is high.
  assign rise  = ce_s &  clk_s & ~clk_prev;
  assign fall  = ce_s & ~clk_s &  clk_prev;
  assign sh_in = {data_s, sh[7:1]};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ce_s) state_nxt = CMD;
      CMD:     if (rise && cnt == 4'd7) state_nxt = sh_in[7] ? RDATA : WDATA;
      WDATA:   if (rise && cnt == 4'd7) state_nxt = DONE;
      RDATA:   if (fall && cnt == 4'd8) state_nxt = DONE;
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
    if (!ce_s) state_nxt = IDLE;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt        <= '0;
      sh         <= '0;
      tx         <= '0;
      idx        <= '0;
      o_ser_data <= 1'b0;
      o_ser_oe   <= 1'b0;
      o_wr_valid <= 1'b0;
      o_wr_addr  <= '0;
      o_wr_data  <= '0;
      o_rd_valid <= 1'b0;
      o_loc_data <= '0;
      for (int i = 0; i < DEPTH; i++) file[i] <= RESET_VAL;
    end else begin
      o_wr_valid <= 1'b0;
      o_rd_valid <= 1'b0;
      o_loc_data <= file[i_loc_addr];
      case (state)
        IDLE: begin
          cnt <= '0;
          sh  <= '0;
        end
        CMD: if (rise) begin
          sh  <= sh_in;
          cnt <= cnt + 4'd1;
          if (cnt == 4'd7) begin
            idx <= sh_in[ADDR_W-1:0];
            tx  <= file[sh_in[ADDR_W-1:0]];
            cnt <= '0;
          end
        end
        WDATA: if (rise) begin
          sh  <= sh_in;
          cnt <= cnt + 4'd1;
          if (cnt == 4'd7) begin
            file[idx]  <= sh_in;
            o_wr_addr  <= idx;
            o_wr_data  <= sh_in;
            o_wr_valid <= 1'b1;
          end
        end
        RDATA: if (fall) begin
          // Falls 1..8 present bits 0..7; the 9th fall releases the line.
          cnt <= cnt + 4'd1;
          if (cnt == 4'd0) begin
            o_ser_oe   <= 1'b1;
            o_ser_data <= tx[0];
          end else if (cnt < 4'd8) begin
            tx         <= {1'b0, tx[7:1]};
            o_ser_data <= tx[1];
          end else begin
            o_ser_oe   <= 1'b0;
            o_rd_valid <= 1'b1;
          end
        end
        DONE:    o_ser_oe <= 1'b0;
        default: o_ser_oe <= 1'b0;
      endcase
      if (!ce_s) o_ser_oe <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ser3w_reg_slave.sv
// Directed bench for ser3w_reg_slave: bench-side serial master, vector table plus corner-case sequences.
`timescale 1ns/1ps
module tb_ser3w_reg_slave;

  localparam int ADDR_W = 7;
  localparam int H      = 6;   // i_clk cycles per ser_clk phase

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b1;
  logic              ser_ce = 1'b0;
  logic              ser_clk = 1'b0;
  logic              mst_data = 1'b0;
  logic              ser_line;
  logic              o_ser_data, o_ser_oe, o_wr_valid, o_rd_valid, o_busy;
  logic [ADDR_W-1:0] o_wr_addr;
  logic [7:0]        o_wr_data, o_loc_data;
  logic [ADDR_W-1:0] loc_addr = '0;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  logic       wr_prev = 1'b0;
  logic [7:0] loc_at = '0;
  logic [7:0] loc_after = '0;

  assign ser_line = o_ser_oe ? o_ser_data : mst_data;

  ser3w_reg_slave #(.ADDR_W(ADDR_W), .SYNC_STAGES(2), .RESET_VAL(8'h3C)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_ser_ce(ser_ce), .i_ser_clk(ser_clk),
    .i_ser_data(ser_line), .o_ser_data(o_ser_data), .o_ser_oe(o_ser_oe),
    .o_wr_valid(o_wr_valid), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
    .o_rd_valid(o_rd_valid), .o_busy(o_busy), .i_loc_addr(loc_addr),
    .o_loc_data(o_loc_data)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) begin
    if (o_wr_valid) begin
      wr_cnt = wr_cnt + 1;
      loc_at = o_loc_data;
    end
    if (wr_prev) loc_after = o_loc_data;
    wr_prev = o_wr_valid;
    if (o_rd_valid) rd_cnt = rd_cnt + 1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic pulse(input logic b, output logic smp, output logic oe_s);
    mst_data = b;
    wait_cyc(H);
    smp  = ser_line;
    oe_s = o_ser_oe;
    ser_clk = 1'b1;
    wait_cyc(H);
    ser_clk = 1'b0;
  endtask

  // Full or truncated transaction; ndat = data/read bits, nextra = pulses after them.
  task automatic run_txn(input logic [7:0] cmd, input logic [7:0] dat, input int ndat,
                         input int nextra, output logic [7:0] rd, output logic oe_all,
                         output logic oe_extra, output logic oe_done);
    logic smp, oes;
    rd = '0; oe_all = 1'b1; oe_extra = 1'b0;
    ser_ce = 1'b1;
    wait_cyc(H);
    for (int i = 0; i < 8; i++) pulse(cmd[i], smp, oes);
    for (int i = 0; i < ndat; i++) begin
      pulse(cmd[7] ? 1'b0 : dat[i], smp, oes);
      rd[i] = smp;
      oe_all = oe_all & oes;
    end
    for (int i = 0; i < nextra; i++) begin
      pulse(1'b1, smp, oes);
      oe_extra = oe_extra | oes;
    end
    wait_cyc(H);
    oe_done = o_ser_oe;
    mst_data = 1'b0;
    ser_ce = 1'b0;
    wait_cyc(2 * H);
  endtask

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] dat;
    logic [7:0] exp_byte;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [7:0] rd;
    logic oe_all, oe_extra, oe_done;
    int w0, r0;

    vecs[0] = '{8'h05, 8'hA3, 8'hA3};
    vecs[1] = '{8'h85, 8'h00, 8'hA3};
    vecs[2] = '{8'hFF, 8'h00, 8'h3C};
    vecs[3] = '{8'h7F, 8'h81, 8'h81};
    vecs[4] = '{8'hFF, 8'h00, 8'h81};
    vecs[5] = '{8'hC5, 8'h00, 8'h3C};

    wait_cyc(4);
    check("rst_oe", o_ser_oe, 0);
    check("rst_ser_data", o_ser_data, 0);
    check("rst_wr_valid", o_wr_valid, 0);
    check("rst_wr_addr", o_wr_addr, 0);
    check("rst_wr_data", o_wr_data, 0);
    check("rst_rd_valid", o_rd_valid, 0);
    check("rst_busy", o_busy, 0);
    check("rst_loc_data", o_loc_data, 0);
    i_rst = 1'b0;
    wait_cyc(3);
    check("rst_file_val", o_loc_data, 8'h3C);

    for (int v = 0; v < 6; v++) begin
      w0 = wr_cnt; r0 = rd_cnt;
      run_txn(vecs[v].cmd, vecs[v].dat, 8, 0, rd, oe_all, oe_extra, oe_done);
      if (vecs[v].cmd[7]) begin
        check($sformatf("v%0d_rd_byte", v), rd, vecs[v].exp_byte);
        check($sformatf("v%0d_oe_during", v), oe_all, 1);
        check($sformatf("v%0d_oe_done", v), oe_done, 0);
        check($sformatf("v%0d_rd_pulses", v), rd_cnt - r0, 1);
        check($sformatf("v%0d_wr_pulses", v), wr_cnt - w0, 0);
      end else begin
        check($sformatf("v%0d_wr_pulses", v), wr_cnt - w0, 1);
        check($sformatf("v%0d_wr_addr", v), o_wr_addr, vecs[v].cmd[6:0]);
        check($sformatf("v%0d_wr_data", v), o_wr_data, vecs[v].exp_byte);
        check($sformatf("v%0d_rd_pulses", v), rd_cnt - r0, 0);
        loc_addr = vecs[v].cmd[6:0];
        wait_cyc(2);
        check($sformatf("v%0d_loc", v), o_loc_data, vecs[v].exp_byte);
      end
    end

    // Write aborted after 4 data bits, then a full write to the same index.
    w0 = wr_cnt;
    run_txn(8'h10, 8'hFF, 4, 0, rd, oe_all, oe_extra, oe_done);
    check("abort_wr_pulses", wr_cnt - w0, 0);
    loc_addr = 7'h10;
    wait_cyc(2);
    check("abort_file", o_loc_data, 8'h3C);
    run_txn(8'h10, 8'h5A, 8, 0, rd, oe_all, oe_extra, oe_done);
    check("rewrite_wr_pulses", wr_cnt - w0, 1);
    check("rewrite_wr_addr", o_wr_addr, 7'h10);
    check("rewrite_wr_data", o_wr_data, 8'h5A);
    wait_cyc(2);
    check("rewrite_loc", o_loc_data, 8'h5A);

    // Read aborted after 3 bits: no completion pulse, line released.
    r0 = rd_cnt;
    run_txn(8'h85, 8'h00, 3, 0, rd, oe_all, oe_extra, oe_done);
    check("rd_abort_pulses", rd_cnt - r0, 0);
    check("rd_abort_oe", o_ser_oe, 0);

    // Reset while bit 3 of a read of index 0x05 (0xA3) is on the line.
    begin
      logic smp, oes;
      ser_ce = 1'b1;
      wait_cyc(H);
      for (int i = 0; i < 8; i++) pulse(i == 0 || i == 2 || i == 7, smp, oes);
      for (int i = 0; i < 3; i++) pulse(1'b0, smp, oes);
      wait_cyc(H);
      check("midrd_oe_before", o_ser_oe, 1);
      check("midrd_bit3", ser_line, 0);
      #2 i_rst = 1'b1;
      #1 check("midrd_oe_async", o_ser_oe, 0);
      ser_ce = 1'b0;
      wait_cyc(3);
      check("midrd_busy", o_busy, 0);
      check("midrd_wr_addr", o_wr_addr, 0);
      check("midrd_wr_data", o_wr_data, 0);
      check("midrd_loc", o_loc_data, 0);
      i_rst = 1'b0;
      loc_addr = 7'h05;
      wait_cyc(3);
      check("midrd_file_reset", o_loc_data, 8'h3C);
    end

    // Extra pulses after a write; local read of the index during the commit cycle.
    loc_addr = 7'h22;
    w0 = wr_cnt;
    run_txn(8'h22, 8'h99, 8, 3, rd, oe_all, oe_extra, oe_done);
    check("extra_wr_pulses", wr_cnt - w0, 1);
    check("extra_oe", oe_extra, 0);
    check("commit_loc_old", loc_at, 8'h3C);
    check("commit_loc_new", loc_after, 8'h99);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
